// File: rtl/preload_sequencer.sv
// preload_sequencer: streams ROWS*COLS weight beats into a systolic mesh.
// Each accepted beat becomes one registered mesh write one cycle later,
// addressed {row, col} with the column running fastest. After the final
// beat the FSM drains for one cycle, then pulses start/done together.
// Optional feature: define PRELOAD_CHECKSUM_EN to add a 16-bit wrapping
// checksum output (csum) of the sign-extended accepted beats.
//
// Handshake: a beat transfers on a rising edge where s_valid && s_ready.
// s_ready is combinational, (state == LOAD && !abort). s_valid may be
// dropped at any time; a dropped cycle stalls the beat counter.
module preload_sequencer #(
  parameter int DW    = 8,
  parameter int ROWS  = 4,
  parameter int COLS  = 16,
  parameter int ROW_W = 2,
  parameter int COL_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_req,
  input  logic                   abort,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic signed [DW-1:0]   s_data,
  output logic                   preload_valid,
  output logic [ROW_W+COL_W-1:0] preload_addr,
  output logic signed [DW-1:0]   preload_data,
  output logic                   start,
  output logic                   busy,
  output logic                   done,
`ifdef PRELOAD_CHECKSUM_EN
  output logic [15:0]            csum,
`endif
  output logic [1:0]             state_dbg
);

  localparam int AW   = ROW_W + COL_W;
  localparam int LAST = ROWS * COLS - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    FIRE  = 2'd3
  } state_t;

  state_t               state_q;
  logic                 fire_q;
  logic [AW-1:0]        cnt_q, cnt_d;
  logic                 pv_q;
  logic [AW-1:0]        addr_q;
  logic signed [DW-1:0] data_q;
  logic                 accept;
  logic                 last_beat;
  logic                 kill;
  logic                 begin_load;

  assign s_ready    = (state_q == LOAD) && !abort;
  assign accept     = s_valid && s_ready;
  assign last_beat  = accept && (cnt_q == AW'(LAST));
  assign kill       = abort && ((state_q == LOAD) || (state_q == DRAIN));
  assign begin_load = (state_q == IDLE) && load_req;

  // Sequencing FSM; fire_q is high exactly while the state is FIRE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      fire_q  <= 1'b0;
    end else begin
      fire_q <= 1'b0;
      case (state_q)
        IDLE:    if (load_req) state_q <= LOAD;
        LOAD: begin
          if (abort)          state_q <= IDLE;
          else if (last_beat) state_q <= DRAIN;
        end
        DRAIN: begin
          if (abort) begin
            state_q <= IDLE;
          end else begin
            state_q <= FIRE;
            fire_q  <= 1'b1;
          end
        end
        FIRE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Beat counter: restarts at 0 for every new load and on abort.
  always_comb begin
    cnt_d = cnt_q;
    if (kill || begin_load) cnt_d = '0;
    else if (accept)        cnt_d = cnt_q + AW'(1);
  end

  // Mesh write port: one registered write per accepted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      pv_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      pv_q  <= accept;
      if (accept) begin
        addr_q <= cnt_q;
        data_q <= s_data;
      end
    end
  end

`ifdef PRELOAD_CHECKSUM_EN
  logic [15:0] csum_q;

  // Running checksum; frozen through DRAIN/FIRE so it is stable at done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_q <= '0;
    end else if (kill || begin_load) begin
      csum_q <= '0;
    end else if (accept) begin
      csum_q <= csum_q + 16'(s_data);
    end
  end

  assign csum = csum_q;
`endif

  assign preload_valid = pv_q;
  assign preload_addr  = addr_q;
  assign preload_data  = data_q;
  assign start         = fire_q;
  assign done          = fire_q;
  assign busy          = (state_q != IDLE);
  assign state_dbg     = state_q;

endmodule

// File: doc/preload_sequencer.md
PRELOAD_SEQUENCER -- requirements
Module: preload_sequencer

Interface
REQ-001 SHALL have parameter DW, default 8, weight data width.
REQ-002 SHALL have parameter ROWS, default 4, mesh rows.
REQ-003 SHALL have parameter COLS, default 16, mesh columns.
REQ-004 SHALL have parameter ROW_W, default 2, row index width.
REQ-005 SHALL have parameter COL_W, default 4, column index width.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic on the rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port load_req, input, 1, request to begin one full weight load.
REQ-009 SHALL have port abort, input, 1, cancel the load in progress.
REQ-010 SHALL have port s_valid, input, 1, weight beat valid.
REQ-011 SHALL have port s_ready, output, 1, weight beat accepted when s_valid is also high.
REQ-012 SHALL have port s_data, input, DW (signed), weight beat.
REQ-013 SHALL have port preload_valid, output, 1, mesh write strobe.
REQ-014 SHALL have port preload_addr, output, ROW_W+COL_W, {row, col} mesh address.
REQ-015 SHALL have port preload_data, output, DW (signed), mesh write data.
REQ-016 SHALL have port start, output, 1, one-cycle compute-start pulse to the FSM controller.
REQ-017 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-018 SHALL have port done, output, 1, one-cycle completion pulse.

Function
REQ-019 SHALL implement the states IDLE, LOAD, DRAIN and FIRE.
REQ-020 IDLE SHALL go to LOAD on load_req; load_req SHALL be ignored in any other state.
REQ-021 s_ready SHALL be the combinational function (state==LOAD && !abort).
REQ-022 Every accepted beat in cycle N SHALL produce preload_valid=1 in cycle N+1, with preload_data equal to that beat (latency 1, registered).
REQ-023 Beat index k (0..ROWS*COLS-1) SHALL map to preload_addr = {k/COLS, k%COLS}, column fastest, via a ROW_W+COL_W-bit beat counter.
REQ-024 preload_valid SHALL be 0 in any cycle following a cycle with no accepted beat; gaps in s_valid SHALL stall the counter.
REQ-025 Acceptance of beat ROWS*COLS-1 SHALL move the state LOAD->DRAIN, then DRAIN->FIRE, then FIRE->IDLE.
REQ-026 start and done SHALL both be 1 exactly while the state is FIRE, i.e. two cycles after the last beat is accepted and one cycle after the last preload_valid.
REQ-027 abort in LOAD or DRAIN SHALL return the state to IDLE on the next edge with no start or done, clear the beat counter, and force preload_valid to 0 next cycle.
REQ-028 abort in IDLE or FIRE SHALL have no effect.
REQ-029 When abort and a beat coincide, no beat SHALL be accepted (REQ-021).
REQ-030 A new load SHALL always begin at address 0.

Reset
REQ-031 rst SHALL asynchronously force state IDLE and beat counter 0.
REQ-032 rst SHALL force preload_valid, preload_addr, preload_data, start, done, busy and s_ready to 0.
REQ-033 Reset asserted mid-load SHALL discard the partial load; after release the block SHALL wait for a fresh load_req.

Configuration
REQ-034 When macro PRELOAD_CHECKSUM_EN is defined, the block SHALL add output csum, 16 bits: the wrapping sum of the sign-extended accepted beats.
REQ-035 With PRELOAD_CHECKSUM_EN defined, csum SHALL be cleared on reset, on the IDLE->LOAD transition and on abort, and SHALL be valid and stable while done=1.
REQ-036 Without PRELOAD_CHECKSUM_EN, the csum port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-037 Stimulus: reset, load_req, then 64 back-to-back beats with data=k. Required: preload_addr runs 0..63 with data k, one cycle after each accept; start=done=1 exactly two cycles after beat 63; busy=0 the cycle after.
REQ-038 Stimulus: beats with s_valid toggling 1,0,1,0. Required: preload_valid shows the same gap pattern delayed by one cycle; addresses contiguous; start only after 64 accepts.
REQ-039 Stimulus: abort after beat 20. Required: s_ready=0 that cycle; no start; a following load_req restarts at addr 0.
REQ-040 Stimulus: rst pulse after beat 40. Required: all outputs 0 immediately; a fresh load completes normally.
REQ-041 Stimulus: load_req asserted during LOAD, and s_valid asserted in IDLE. Required: both ignored; s_ready=0 in IDLE.
REQ-042 Stimulus: with PRELOAD_CHECKSUM_EN defined, 64 beats of data -1 (8'hFF). Required: csum=16'hFFC0 at done.
